// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the configurable transmitter and receiver
package uart_pkg;

  // Frame sequencing states shared by the tx and rx sides
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Parity selection encodings; 2'b11 behaves as none
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Widest legal data word; helpers take data zero-extended to this width
  localparam int MAX_DATA_W = 9;

  // True when the mode inserts a parity bit into the frame
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit value; zero-extension does not change the XOR reduction
  function automatic logic parity_bit(input logic [1:0] mode,
                                      input logic [MAX_DATA_W-1:0] data);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period down-counter with end-of-bit strobe
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  output logic             bit_end
);

  logic [DIV_W-1:0] count;

  // Load the period at each bit start, then count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= period;
    end else if (count != '0) begin
      count <= count - DIV_W'(1);
    end
  end

  // The current bit ends in the cycle the counter reads zero
  assign bit_end = (count == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with parity and 1/2 stop bits
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_tx,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic [DATA_W-1:0] d_in,
  input  logic              d_valid,
  output logic              d_ready,
  output logic              txd,
  output logic              sending,
  output logic              frame_done
);

  localparam int               IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  uart_tx_state_t state, state_next;

  logic [DATA_W-1:0]     shreg, shreg_d;
  logic [MAX_DATA_W-1:0] d_ext;
  logic [DIV_W-1:0]      baud_q;
  logic                  par_en_q;
  logic                  par_q;
  logic                  two_stop_q;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic                  last_stop;

  logic                  accept;
  logic                  bit_end;
  logic                  tmr_load;
  logic [DIV_W-1:0]      tmr_period;

  logic                  txd_d;
  logic                  sending_d;
  logic                  frame_done_d;

  // Ready only in IDLE while enabled and out of reset
  assign d_ready   = ~rst & enable_tx & (state == IDLE);
  assign accept    = d_valid & d_ready;
  assign last_stop = (stop_idx == two_stop_q);

  // Zero-extend the word for the shared parity helper
  always_comb begin
    d_ext               = '0;
    d_ext[DATA_W-1:0]   = d_in;
  end

  uart_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .period  (tmr_period),
    .bit_end (bit_end)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a dropped enable overrides everything
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == LAST_IDX)) begin
          state_next = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end && last_stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!enable_tx) state_next = IDLE;
  end

  // FSM outputs: line level for the next cycle, shifter and timer control
  always_comb begin
    shreg_d      = shreg;
    txd_d        = 1'b1;
    sending_d    = 1'b0;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_period   = baud_q;

    if (accept) begin
      shreg_d = d_in;
    end else if ((state == DATA) && bit_end) begin
      shreg_d = shreg >> 1;
    end

    case (state_next)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_q;
      default: txd_d = 1'b1;
    endcase

    sending_d    = (state_next != IDLE);
    frame_done_d = (state == STOP) && (state_next == IDLE) && enable_tx;

    // Restart the bit period at acceptance and at every bit boundary inside a frame
    tmr_load   = (state_next != IDLE) && ((state == IDLE) || bit_end);
    tmr_period = (state == IDLE) ? baud_div : baud_q;
  end

  // Registered line outputs and per-frame configuration captured at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd        <= 1'b1;
      sending    <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      baud_q     <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      txd        <= txd_d;
      sending    <= sending_d;
      frame_done <= frame_done_d;
      shreg      <= shreg_d;
      if (accept) begin
        baud_q     <= baud_div;
        par_en_q   <= parity_enabled(parity_mode);
        par_q      <= parity_bit(parity_mode, d_ext);
        two_stop_q <= two_stop;
      end
    end
  end

  // Data bit index: held at zero outside DATA, advances at each data bit end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (state != DATA) begin
      bit_idx <= '0;
    end else if (bit_end) begin
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  // Stop bit index: marks that the first of two stop bits has elapsed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_idx <= 1'b0;
    end else if (state != STOP) begin
      stop_idx <= 1'b0;
    end else if (bit_end) begin
      stop_idx <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_tx;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic [7:0]  d_in;
  logic        d_valid8, d_valid7;
  logic        d_ready8, txd8, sending8, frame_done8;
  logic        d_ready7, txd7, sending7, frame_done7;
  logic        sel;
  logic        obs_txd, obs_sending, obs_done, obs_ready;

  int checks   = 0;
  int failures = 0;
  logic line_q [0:511];
  int n_send, done_at;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .enable_tx   (enable_tx),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .d_in        (d_in),
    .d_valid     (d_valid8),
    .d_ready     (d_ready8),
    .txd         (txd8),
    .sending     (sending8),
    .frame_done  (frame_done8)
  );

  uart_tx_cfg #(.DATA_W(7), .DIV_W(16)) u_dut7 (
    .clk         (clk),
    .rst         (rst),
    .enable_tx   (enable_tx),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .d_in        (d_in[6:0]),
    .d_valid     (d_valid7),
    .d_ready     (d_ready7),
    .txd         (txd7),
    .sending     (sending7),
    .frame_done  (frame_done7)
  );

  assign obs_txd     = sel ? txd7        : txd8;
  assign obs_sending = sel ? sending7    : sending8;
  assign obs_done    = sel ? frame_done7 : frame_done8;
  assign obs_ready   = sel ? d_ready7    : d_ready8;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word, confirm ready, take the accepting edge, then disturb the config inputs
  task automatic accept_word(input logic s, input logic [7:0] d, input logic [15:0] div,
                             input logic [1:0] pm, input logic ts, input logic scramble);
    sel         = s;
    d_in        = d;
    baud_div    = div;
    parity_mode = pm;
    two_stop    = ts;
    if (s) d_valid7 = 1'b1;
    else   d_valid8 = 1'b1;
    #1;
    chk("ready_before_accept", {31'd0, obs_ready}, 32'd1);
    step();
    d_valid7 = 1'b0;
    d_valid8 = 1'b0;
    if (scramble) begin
      d_in        = ~d;
      baud_div    = div + 16'd5;
      parity_mode = pm ^ 2'b11;
      two_stop    = ~ts;
    end
  endtask

  // Record the line from the first start-bit cycle until frame_done, bounded
  task automatic capture(output int ns, output int da);
    ns = 0;
    da = -1;
    for (int c = 0; c < 512; c++) begin
      line_q[c] = obs_txd;
      if (obs_done) begin
        da = c;
        break;
      end
      if (obs_sending) ns++;
      step();
    end
  endtask

  // Compare captured line against an independently built bit list and hand frame length
  task automatic check_frame(input string tag, input logic [8:0] d, input int dw, input int div,
                             input logic [1:0] pm, input logic ts, input int exp_len,
                             input int ns, input int da);
    logic fb [0:15];
    int   nb;
    logic p;
    p     = 1'b0;
    fb[0] = 1'b0;
    for (int i = 0; i < dw; i++) begin
      fb[1+i] = d[i];
      p       = p ^ d[i];
    end
    nb = 1 + dw;
    if (pm == 2'b01) begin
      fb[nb] = p;
      nb     = nb + 1;
    end else if (pm == 2'b10) begin
      fb[nb] = ~p;
      nb     = nb + 1;
    end
    fb[nb] = 1'b1;
    nb     = nb + 1;
    if (ts) begin
      fb[nb] = 1'b1;
      nb     = nb + 1;
    end
    chk({tag, " done_at"}, da, exp_len);
    chk({tag, " sending_len"}, ns, exp_len);
    for (int c = 0; c < exp_len && c < 512; c++) begin
      int   k;
      logic e;
      k = c / (div + 1);
      e = (k < nb) ? fb[k] : 1'b1;
      chk($sformatf("%s txd_c%0d", tag, c), {31'd0, line_q[c]}, {31'd0, e});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_done, cnt_low;
    rst         = 1'b1;
    enable_tx   = 1'b1;
    d_valid8    = 1'b0;
    d_valid7    = 1'b0;
    d_in        = 8'h00;
    baud_div    = 16'd0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    sel         = 1'b0;

    // Reset values while rst is high
    step();
    chk("rst txd", {31'd0, txd8}, 32'd1);
    chk("rst sending", {31'd0, sending8}, 32'd0);
    chk("rst frame_done", {31'd0, frame_done8}, 32'd0);
    chk("rst d_ready", {31'd0, d_ready8}, 32'd0);
    chk("rst txd7", {31'd0, txd7}, 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("idle d_ready", {31'd0, d_ready8}, 32'd1);
    chk("idle txd", {31'd0, txd8}, 32'd1);

    // 8N1, div 3, 0x55: ten 4-cycle cells, frame_done at 40
    accept_word(1'b0, 8'h55, 16'd3, 2'b00, 1'b0, 1'b1);
    capture(n_send, done_at);
    check_frame("8n1", 9'h055, 8, 3, 2'b00, 1'b0, 40, n_send, done_at);
    chk("8n1 ready_at_done", {31'd0, d_ready8}, 32'd1);
    step();

    // Even parity 0x07 div 0: parity 1, 11 cycles
    accept_word(1'b0, 8'h07, 16'd0, 2'b01, 1'b0, 1'b1);
    capture(n_send, done_at);
    check_frame("8e1", 9'h007, 8, 0, 2'b01, 1'b0, 11, n_send, done_at);
    chk("8e1 parity_bit", {31'd0, line_q[9]}, 32'd1);
    step();

    // Odd parity 0x07 div 0: parity 0
    accept_word(1'b0, 8'h07, 16'd0, 2'b10, 1'b0, 1'b1);
    capture(n_send, done_at);
    check_frame("8o1", 9'h007, 8, 0, 2'b10, 1'b0, 11, n_send, done_at);
    chk("8o1 parity_bit", {31'd0, line_q[9]}, 32'd0);
    step();

    // 8N2 div 1, two_stop dropped right after acceptance: still 22 cycles
    accept_word(1'b0, 8'h96, 16'd1, 2'b00, 1'b1, 1'b1);
    capture(n_send, done_at);
    check_frame("8n2", 9'h096, 8, 1, 2'b00, 1'b1, 22, n_send, done_at);
    step();

    // Back-to-back with d_valid held: one idle cycle then the next start bit
    sel         = 1'b0;
    d_in        = 8'hA5;
    baud_div    = 16'd1;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    d_valid8    = 1'b1;
    step();
    d_in = 8'h3C;
    capture(n_send, done_at);
    check_frame("b2b_a5", 9'h0A5, 8, 1, 2'b00, 1'b0, 20, n_send, done_at);
    chk("b2b idle_txd", {31'd0, txd8}, 32'd1);
    chk("b2b ready_at_done", {31'd0, d_ready8}, 32'd1);
    step();
    d_valid8 = 1'b0;
    chk("b2b second_start", {31'd0, txd8}, 32'd0);
    capture(n_send, done_at);
    check_frame("b2b_3c", 9'h03C, 8, 1, 2'b00, 1'b0, 20, n_send, done_at);
    step();

    // Abort by enable_tx low during the data bits
    accept_word(1'b0, 8'h55, 16'd3, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step();
    chk("abort pre_txd", {31'd0, txd8}, 32'd0);
    enable_tx = 1'b0;
    #1;
    chk("abort ready_low", {31'd0, d_ready8}, 32'd0);
    step();
    chk("abort txd", {31'd0, txd8}, 32'd1);
    chk("abort sending", {31'd0, sending8}, 32'd0);
    cnt_done = 0;
    cnt_low  = 0;
    for (int i = 0; i < 50; i++) begin
      if (frame_done8) cnt_done++;
      if (!txd8) cnt_low++;
      step();
    end
    chk("abort no_done", cnt_done, 0);
    chk("abort line_high", cnt_low, 0);
    enable_tx = 1'b1;
    #1;
    chk("abort ready_back", {31'd0, d_ready8}, 32'd1);
    step();

    // Reset pulsed mid-frame
    accept_word(1'b0, 8'h00, 16'd3, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("rstmid pre_txd", {31'd0, txd8}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid txd", {31'd0, txd8}, 32'd1);
    chk("rstmid sending", {31'd0, sending8}, 32'd0);
    chk("rstmid frame_done", {31'd0, frame_done8}, 32'd0);
    chk("rstmid d_ready", {31'd0, d_ready8}, 32'd0);
    step();
    step();
    rst = 1'b0;
    cnt_done = 0;
    cnt_low  = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_done8 || sending8) cnt_done++;
      if (!txd8) cnt_low++;
      step();
    end
    chk("rstmid quiet", cnt_done, 0);
    chk("rstmid no_glitch", cnt_low, 0);

    // DATA_W=7, even parity, 0x7F: seven ones, parity 1, one stop
    accept_word(1'b1, 8'h7F, 16'd1, 2'b01, 1'b0, 1'b1);
    capture(n_send, done_at);
    check_frame("7e1", 9'h07F, 7, 1, 2'b01, 1'b0, 20, n_send, done_at);
    chk("7e1 parity_bit", {31'd0, line_q[16]}, 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter, the successor to the fixed 8-bit button-triggered transmitter. It serialises one word per valid/ready handshake at a runtime-programmable bit period, with selectable parity (none/even/odd) and 1 or 2 stop bits. It sits between the register/buffer controller, which supplies words, and the `txd` pin. The `sending` output is kept for the status LED.

## Interface

- `DATA_W`, 8: data bits per frame, legal range 5–9.
- `DIV_W`, 16: width of the bit-period divisor.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `enable_tx`  in  1  module enable. Low aborts any frame and blocks acceptance.
- `baud_div`  in  DIV_W  bit period minus one, in `clk` cycles. Sampled at acceptance.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none. Sampled at acceptance.
- `two_stop`  in  1  0 gives one stop bit, 1 gives two. Sampled at acceptance.
- `d_in`  in  DATA_W  word to send.
- `d_valid`  in  1  `d_in` is valid.
- `d_ready`  out  1  transmitter can accept a word.
- `txd`  out  1  serial line, idle high.
- `sending`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `d_ready` = `enable_tx`.
  - On `d_valid && d_ready`, latch `d_in`, `baud_div`, `parity_mode` and `two_stop`, then go to START.
- START: `txd`=0 for one bit period.
- DATA
  - Shift out `DATA_W` bits, LSB first, one bit period each.
  - A bit index counter runs 0..DATA_W-1.
- PARITY
  - Entered only if the latched mode is even or odd.
  - Even: `txd` = XOR of the latched data.
  - Odd: `txd` = XNOR of the latched data.
- STOP
  - `txd`=1 for 1 or 2 bit periods.
  - Then pulse `frame_done` and return to IDLE.
- Bit timing
  - The bit-period counter loads the latched `baud_div` at each bit start and decrements.
  - The bit ends in the cycle the counter reaches 0.
  - Bit period is `baud_div`+1 cycles; `baud_div`=0 gives one cycle per bit.
  - Counter is `DIV_W` bits wide; no overflow is possible.
- `sending` = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Input changes to `baud_div`, `parity_mode`, `two_stop` or `d_in` during a frame have no effect on that frame.
- `enable_tx` low in any state
  - Next edge: state IDLE, `txd`=1, `sending`=0.
  - No `frame_done` pulse; the word in flight is dropped.
  - `d_ready`=0 while `enable_tx` is low.
- `d_valid` low in IDLE: no action, line stays high.

## Timing

- Reset values while `rst` high: state IDLE, `txd`=1, `sending`=0, `frame_done`=0, `d_ready`=0, all counters 0.
- `txd`, `sending` and `frame_done` are registered. `d_ready` is combinational from state, `rst` and `enable_tx`.
- Handshake: a word is accepted at the rising edge where `d_valid && d_ready`. The start bit is on `txd` from the next cycle.
- Frame length in cycles, from the first start-bit cycle: (1 + DATA_W + P + S) × (`baud_div`+1), where P = 0/1 and S = 1/2.
- `frame_done` is high in the cycle after the last stop-bit cycle, coincident with the return to IDLE. `d_ready` is high in the same cycle.
- Back-to-back words: at least one IDLE cycle with `txd`=1 separates frames, beyond the stop bits.
- Reset mid-frame: immediate return to IDLE with `txd`=1, and no glitch low after release.

## Structure

- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity constants `PAR_NONE`=2'b00, `PAR_EVEN`=2'b01, `PAR_ODD`=2'b10.
- The package is also used by a future `uart_rx_cfg`.
- One sub-module, `uart_bit_timer`, holds the bit-period down-counter.
  - Inputs: load, period value.
  - Output: `bit_end` strobe.
- The FSM, shift register, parity and stop logic stay in the top module.

## Test plan

- 8N1, `baud_div`=3, `d_in`=0x55:
  - `txd` holds each of 0,1,0,1,0,1,0,1,0,1 for 4 cycles;
  - `frame_done` arrives 40 cycles after the first start cycle;
  - `sending` is high for exactly 40 cycles.
- Even parity, `d_in`=0x07, `baud_div`=0 → parity bit 1, frame 11 cycles. Odd parity with the same data → parity bit 0.
- `two_stop`=1, 8N2, `baud_div`=1 → stop high for 4 cycles, frame 22 cycles. Changing `two_stop` to 0 mid-frame does not shorten the frame.
- Back-to-back words 0xA5 then 0x3C, with `d_valid` held high → second accept exactly 1 cycle after `frame_done`; both frames are bit-exact.
- Abort and reset:
  - `enable_tx` low during the data bits → `txd`=1 and `sending`=0 next cycle, no `frame_done`.
  - `rst` pulsed mid-frame → all outputs at reset values.
- DATA_W=7, even parity, `d_in`=7'h7F → 7 data bits of 1, then parity bit 1, then one stop bit.
